// File: rtl/spu_alu_pkg.sv
// Shared types for the SPU lane-ALU dispatch front end: opcodes, status
// states and the buffered request record.
package spu_alu_pkg;

    typedef enum logic [3:0] {
        OP_SUB = 4'd0,
        OP_ADD = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SHL = 4'd5,
        OP_SHR = 4'd6,
        OP_MUL = 4'd7,
        OP_EQ  = 4'd8
    } alu_op_e;

    localparam logic [3:0] OP_MAX = 4'd8;

    // Width of the tag field inside a buffered request; the dispatch
    // block's TAG_W parameter is expected to equal it.
    localparam int REQ_TAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STALL
    } disp_state_e;

    typedef struct packed {
        logic [127:0]           a;
        logic [127:0]           b;
        logic [3:0]             ctr;
        logic                   half;
        logic [REQ_TAG_W-1:0]   tag;
    } alu_req_t;

endpackage

// File: rtl/spu_req_fifo.sv
// Synchronous request FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate counter.
module spu_req_fifo
    import spu_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  alu_req_t        wdata,
    input  logic            pop,
    output alu_req_t        rdata,
    output logic            full,
    output logic            empty,
    output logic [AW:0]     count
);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    alu_req_t    mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/spu_alu_dispatch.sv
// Issue-side front end of the SPU lane ALU: buffers requests, drives the ALU
// operands from registers and captures results behind a valid/ready port.
module spu_alu_dispatch
    import spu_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = REQ_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [127:0]        req_a,
    input  logic [127:0]        req_b,
    input  logic [3:0]          req_ctr,
    input  logic                req_half,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [127:0]        alu_a,
    output logic [127:0]        alu_b,
    output logic [3:0]          alu_ctr,
    output logic                alu_half,
    input  logic [127:0]        alu_out,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [127:0]        resp_data,
    output logic                resp_zero,
    output logic                resp_err,
    output logic [TAG_W-1:0]    resp_tag,
    output logic                busy,
    output logic [CNT_W-1:0]    issued_cnt
);

    localparam int AW = $clog2(DEPTH);

    alu_req_t       push_entry;
    alu_req_t       head;
    logic           fifo_full;
    logic           fifo_empty;
    logic [AW:0]    fifo_count;
    logic           s1_valid;
    logic [TAG_W-1:0] s1_tag;
    disp_state_e    state_q;
    disp_state_e    state_d;

    assign push_entry = '{a: req_a, b: req_b, ctr: req_ctr, half: req_half, tag: req_tag};

    // A request offered during flush is dropped along with the queue.
    logic push;
    logic s1_adv;
    logic s1_load;
    logic s2_capture;
    assign req_ready  = !fifo_full;
    assign push       = req_valid && !fifo_full && !flush;
    assign s1_adv     = s1_valid && (!resp_valid || resp_ready);
    assign s1_load    = !fifo_empty && (!s1_valid || s1_adv) && !flush;
    assign s2_capture = s1_adv && !flush;

    spu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .wdata (push_entry),
        .pop   (s1_load),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Occupancy after the coming edge, shared by the stage registers and the FSM.
    logic s1_valid_d;
    logic resp_valid_d;
    logic fifo_empty_d;
    logic busy_d;
    assign s1_valid_d   = !flush && (s1_load || (s1_valid && !s1_adv));
    assign resp_valid_d = s2_capture || (resp_valid && !resp_ready);
    assign fifo_empty_d = flush || (fifo_empty && !push)
                        || (fifo_count == {{AW{1'b0}}, 1'b1} && s1_load && !push);
    assign busy_d       = !fifo_empty_d || s1_valid_d || resp_valid_d;
    assign busy         = !fifo_empty || s1_valid || resp_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctr    <= '0;
            alu_half   <= 1'b0;
            s1_tag     <= '0;
            issued_cnt <= '0;
        end else begin
            s1_valid <= s1_valid_d;
            if (s1_load) begin
                alu_a      <= head.a;
                alu_b      <= head.b;
                alu_ctr    <= head.ctr;
                alu_half   <= head.half;
                s1_tag     <= head.tag;
                issued_cnt <= issued_cnt + 1'b1;
            end
        end
    end

    logic         op_err;
    logic [127:0] cap_data;
    assign op_err   = (alu_ctr > OP_MAX);
    assign cap_data = op_err ? '0 : alu_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_zero  <= 1'b0;
            resp_err   <= 1'b0;
            resp_tag   <= '0;
        end else begin
            resp_valid <= resp_valid_d;
            if (s2_capture) begin
                resp_data <= cap_data;
                resp_zero <= (cap_data == '0);
                resp_err  <= op_err;
                resp_tag  <= s1_tag;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // NOTE: next state gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (push) state_d = ST_RUN;
            ST_RUN: begin
                if (s1_valid && resp_valid && !resp_ready)
                    state_d = ST_STALL;
                else if (!busy_d)
                    state_d = ST_IDLE;
            end
            ST_STALL: if (resp_ready) state_d = ST_RUN;
            default:  state_d = ST_IDLE;
        endcase
    end

    a_busy_not_idle: assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> state_q != ST_IDLE);
    a_stall_has_resp: assert property (@(posedge clk) disable iff (!rst_n)
        state_q == ST_STALL |-> resp_valid);

endmodule

// File: tb/tb_spu_alu_dispatch.sv
// Self-checking bench for spu_alu_dispatch: a lane ALU model on alu_out, a
// request-order scoreboard checked every cycle, and directed literal checks.
module tb_spu_alu_dispatch;
    import spu_alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CNT_W = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               flush;
    logic               req_valid;
    logic               req_ready;
    logic [127:0]       req_a;
    logic [127:0]       req_b;
    logic [3:0]         req_ctr;
    logic               req_half;
    logic [TAG_W-1:0]   req_tag;
    logic [127:0]       alu_a;
    logic [127:0]       alu_b;
    logic [3:0]         alu_ctr;
    logic               alu_half;
    logic [127:0]       alu_out;
    logic               resp_valid;
    logic               resp_ready;
    logic [127:0]       resp_data;
    logic               resp_zero;
    logic               resp_err;
    logic [TAG_W-1:0]   resp_tag;
    logic               busy;
    logic [CNT_W-1:0]   issued_cnt;

    spu_alu_dispatch #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ctr    (req_ctr),
        .req_half   (req_half),
        .req_tag    (req_tag),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctr    (alu_ctr),
        .alu_half   (alu_half),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_zero  (resp_zero),
        .resp_err   (resp_err),
        .resp_tag   (resp_tag),
        .busy       (busy),
        .issued_cnt (issued_cnt)
    );

    always #5 clk = ~clk;

    // Lane-wise SIMD ALU: 8 x 16-bit lanes or 4 x 32-bit lanes.
    function automatic logic [127:0] tb_alu(input logic [127:0] a, input logic [127:0] b,
                                            input logic [3:0] ctr, input logic half);
        logic [127:0] r;
        logic [31:0]  x, y, z;
        r = '0;
        for (int i = 0; i < (half ? 8 : 4); i++) begin
            x = half ? {16'h0, a[i*16 +: 16]} : a[i*32 +: 32];
            y = half ? {16'h0, b[i*16 +: 16]} : b[i*32 +: 32];
            case (ctr)
                4'd0: z = x - y;
                4'd1: z = x + y;
                4'd2: z = x & y;
                4'd3: z = x | y;
                4'd4: z = x ^ y;
                4'd5: z = half ? x << y[3:0] : x << y[4:0];
                4'd6: z = half ? x >> y[3:0] : x >> y[4:0];
                4'd7: z = x * y;
                4'd8: z = (x == y) ? 32'hFFFF_FFFF : 32'h0;
                default: z = 32'hDEAD_BEEF;
            endcase
            if (half) r[i*16 +: 16] = z[15:0];
            else      r[i*32 +: 32] = z;
        end
        return r;
    endfunction

    assign alu_out = tb_alu(alu_a, alu_b, alu_ctr, alu_half);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [127:0]     data;
        logic             zero;
        logic             err;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t exp_q[$];
    int   cyc      = 0;
    int   hs_count = 0;
    int   hs_first = 0;
    int   hs_last  = 0;

    // Scoreboard: every accepted request yields one response, in order.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 1'b1, 1'b0);
                end else begin
                    check("sb_data", resp_data, exp_q[0].data);
                    check("sb_zero", resp_zero, exp_q[0].zero);
                    check("sb_err",  resp_err,  exp_q[0].err);
                    check("sb_tag",  resp_tag,  exp_q[0].tag);
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        if (hs_count == 0) hs_first = cyc;
                        hs_last = cyc;
                        hs_count++;
                    end
                end
            end
            if (flush) begin
                if (resp_valid && !resp_ready)
                    while (exp_q.size() > 1) void'(exp_q.pop_back());
                else
                    exp_q.delete();
            end
            if (req_valid && req_ready && !flush) begin
                e.err  = (req_ctr > 4'd8);
                e.data = e.err ? 128'h0 : tb_alu(req_a, req_b, req_ctr, req_half);
                e.zero = (e.data == 128'h0);
                e.tag  = req_tag;
                exp_q.push_back(e);
            end
        end
    end

    task automatic push_req(input logic [127:0] a, input logic [127:0] b, input logic [3:0] ctr,
                            input logic half, input logic [TAG_W-1:0] tag, output int waited);
        bit done;
        req_a = a; req_b = b; req_ctr = ctr; req_half = half; req_tag = tag;
        req_valid = 1'b1;
        waited = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            else begin
                waited++;
                if (waited >= 200) begin
                    check("push_timeout", 1'b0, 1'b1);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        if (!done) check(name, 1'b0, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic one_op(input string name, input logic [127:0] a, input logic [127:0] b,
                          input logic [3:0] ctr, input logic half, input logic [TAG_W-1:0] tag,
                          input logic [127:0] exp_data, input logic exp_zero, input logic exp_err);
        int  w;
        bit  seen;
        push_req(a, b, ctr, half, tag, w);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 1'b0, 1'b1);
        else begin
            check({name, "_data"}, resp_data, exp_data);
            check({name, "_zero"}, resp_zero, exp_zero);
            check({name, "_err"},  resp_err,  exp_err);
            check({name, "_tag"},  resp_tag,  tag);
        end
        @(posedge clk); #1;
        wait_idle({name, "_idle"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [127:0] va [6];
    logic [127:0] vb [6];
    logic [3:0]   vc [6];
    logic         vh [6];

    initial begin
        int w;
        rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_a = '0; req_b = '0; req_ctr = '0; req_half = 1'b0; req_tag = '0;

        #3;
        check("rst_req_ready",  req_ready,  1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_alu_a",      alu_a,      128'h0);
        check("rst_busy",       busy,       1'b0);
        check("rst_issued",     issued_cnt, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single add with latency check.
        resp_ready = 1'b1;
        push_req(128'd100000, 128'd100000, 4'(OP_ADD), 1'b0, 4'd3, w);
        req_valid = 1'b0;
        @(negedge clk);
        check("lat_t0_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        check("lat_t1_alu_a",      alu_a,      128'd100000);
        check("lat_t1_alu_b",      alu_b,      128'd100000);
        check("lat_t1_alu_ctr",    alu_ctr,    4'd1);
        check("lat_t1_resp_valid", resp_valid, 1'b0);
        @(negedge clk);
        check("lat_t2_resp_valid", resp_valid, 1'b1);
        check("add_data",          resp_data,  128'd200000);
        check("add_zero",          resp_zero,  1'b0);
        check("add_tag",           resp_tag,   4'd3);
        @(posedge clk); #1;
        wait_idle("add_idle");
        check("add_issued", issued_cnt, 16'd1);

        // Back-to-back, responses consumed every cycle.
        va[0] = 128'h0000_0005_0000_0007; vb[0] = 128'h0000_0003_0000_0009; vc[0] = 4'(OP_ADD); vh[0] = 1'b0;
        va[1] = 128'h0001_FFFF;           vb[1] = 128'h0001_0001;           vc[1] = 4'(OP_ADD); vh[1] = 1'b1;
        va[2] = 128'hF0F0_F0F0_AAAA_5555; vb[2] = 128'h0FF0_0FF0_FFFF_0000; vc[2] = 4'(OP_XOR); vh[2] = 1'b0;
        va[3] = 128'h0000_0001_0000_0003; vb[3] = 128'h0000_0004_0000_001F; vc[3] = 4'(OP_SHL); vh[3] = 1'b0;
        va[4] = 128'h1234_5678;           vb[4] = 128'h0003_0010;           vc[4] = 4'(OP_MUL); vh[4] = 1'b1;
        va[5] = 128'h8000_0000;           vb[5] = 128'h0000_0004;           vc[5] = 4'(OP_SHR); vh[5] = 1'b0;
        hs_count = 0;
        for (int i = 0; i < 6; i++) begin
            push_req(va[i], vb[i], vc[i], vh[i], 4'(i + 8), w);
            check("b2b_req_ready_wait", w, 0);
        end
        req_valid = 1'b0;
        wait_idle("b2b_idle");
        check("b2b_resp_count", hs_count, 6);
        check("b2b_consecutive", hs_last - hs_first, 5);
        check("b2b_issued", issued_cnt, 16'd7);

        // Backpressure: fill S2, S1 and the FIFO, then drain.
        resp_ready = 1'b0;
        hs_count = 0;
        for (int i = 0; i < 6; i++)
            push_req(128'(i * 3 + 1), 128'(i + 2), 4'(OP_ADD), 1'b0, 4'(i), w);
        req_a = 128'd77; req_b = 128'd1; req_ctr = 4'(OP_ADD); req_tag = 4'd6; req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_req_ready", req_ready, 1'b0);
            check("bp_resp_valid", resp_valid, 1'b1);
            check("bp_resp_tag", resp_tag, 4'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        resp_ready = 1'b1;
        wait_idle("bp_idle");
        check("bp_resp_count", hs_count, 6);
        check("bp_issued", issued_cnt, 16'd13);

        // Zero, compare, lane mode and illegal opcode.
        one_op("sub_zero", 128'd1000, 128'd1000, 4'(OP_SUB), 1'b0, 4'd1, 128'h0, 1'b1, 1'b0);
        one_op("eq", 128'd1000, 128'd10, 4'(OP_EQ), 1'b0, 4'd2,
               {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0}, 1'b0, 1'b0);
        one_op("half_add", 128'h0001_FFFF, 128'h0001_0001, 4'(OP_ADD), 1'b1, 4'd4,
               128'h0002_0000, 1'b0, 1'b0);
        one_op("illegal", 128'd5, 128'd6, 4'hF, 1'b0, 4'd5, 128'h0, 1'b1, 1'b1);
        check("ops_issued", issued_cnt, 16'd17);

        // Flush with S2 stalled: only the pending response survives.
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            push_req(128'(i + 40), 128'd2, 4'(OP_ADD), 1'b0, 4'(i + 10), w);
        flush = 1'b1;
        req_a = 128'd99; req_b = 128'd1; req_ctr = 4'(OP_ADD); req_tag = 4'd15; req_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        req_valid = 1'b0;
        hs_count = 0;
        resp_ready = 1'b1;
        wait_idle("flush_idle");
        check("flush_resp_count", hs_count, 1);
        check("flush_busy", busy, 1'b0);
        check("flush_issued", issued_cnt, 16'd19);

        // Asynchronous reset in the middle of traffic.
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            push_req(128'(i + 1), 128'd1, 4'(OP_OR), 1'b0, 4'(i), w);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready",  req_ready,  1'b1);
        check("arst_resp_valid", resp_valid, 1'b0);
        check("arst_resp_data",  resp_data,  128'h0);
        check("arst_resp_tag",   resp_tag,   4'd0);
        check("arst_alu_a",      alu_a,      128'h0);
        check("arst_alu_ctr",    alu_ctr,    4'd0);
        check("arst_busy",       busy,       1'b0);
        check("arst_issued",     issued_cnt, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_req_ready", req_ready, 1'b1);
        one_op("post_rst_add", 128'd5, 128'd7, 4'(OP_ADD), 1'b0, 4'd9, 128'd12, 1'b0, 1'b0);
        check("post_rst_issued", issued_cnt, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
